// File: rtl/pipelined_shifter_pkg.sv
// Shared definitions for the pipelined shifter: operation encodings, default sizes
// and the constant log2 helper used to size the stage chain.
package pipelined_shifter_pkg;

    localparam int unsigned DefaultWidth = 32;
    localparam int unsigned DefaultTagw  = 4;

    // Codes 3'b101..3'b111 are reserved and pass the operand through untouched.
    typedef enum logic [2:0] {
        OpSrl = 3'b000,
        OpSll = 3'b001,
        OpSra = 3'b010,
        OpRor = 3'b011,
        OpRol = 3'b100
    } op_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/shifter_stage.sv
// One pipeline stage: conditionally shifts/rotates by AMT when its shift-amount bit
// is set, and registers the data with the operation's valid, op, tag and control bits.
module shifter_stage
    import pipelined_shifter_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned AMT   = 1,
    parameter int unsigned TAGW  = DefaultTagw,
    parameter int unsigned SHW   = clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [2:0]       op_i,
    input  logic [TAGW-1:0]  tag_i,
    input  logic             ovr_i,
    input  logic [SHW-1:0]   sh_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [2:0]       op_o,
    output logic [TAGW-1:0]  tag_o,
    output logic             ovr_o,
    output logic [SHW-1:0]   sh_o
);

    localparam int unsigned Bit = clog2(AMT);

    logic             valid_q;
    logic [WIDTH-1:0] data_d, data_q;
    logic [2:0]       op_q;
    logic [TAGW-1:0]  tag_q;
    logic             ovr_q;
    logic [SHW-1:0]   sh_q;

    always_comb begin
        data_d = data_i;
        if (sh_i[Bit]) begin
            case (op_i)
                OpSrl:   data_d = data_i >> AMT;
                OpSll:   data_d = data_i << AMT;
                OpSra:   data_d = $signed(data_i) >>> AMT;
                OpRor:   data_d = {data_i[AMT-1:0], data_i[WIDTH-1:AMT]};
                OpRol:   data_d = {data_i[WIDTH-AMT-1:0], data_i[WIDTH-1:WIDTH-AMT]};
                default: data_d = data_i;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            op_q    <= '0;
            tag_q   <= '0;
            ovr_q   <= 1'b0;
            sh_q    <= '0;
        end else if (en_i) begin
            valid_q <= valid_i;
            data_q  <= data_d;
            op_q    <= op_i;
            tag_q   <= tag_i;
            ovr_q   <= ovr_i;
            sh_q    <= sh_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign op_o    = op_q;
    assign tag_o   = tag_q;
    assign ovr_o   = ovr_q;
    assign sh_o    = sh_q;

endmodule

// File: rtl/pipelined_shifter.sv
// Barrel shifter/rotator split into log2(WIDTH) registered stages with a global
// stall; overrange and sign-fill are resolved after the last stage.
module pipelined_shifter
    import pipelined_shifter_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned TAGW  = DefaultTagw
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] d_i,
    input  logic [WIDTH-1:0] s_i,
    input  logic [2:0]       op_i,
    input  logic [TAGW-1:0]  tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] y_o,
    output logic [TAGW-1:0]  tag_o,
    output logic             op_err_o
);

    localparam int unsigned Log2W = clog2(WIDTH);

    logic             stall;
    logic             advance;
    logic [Log2W:0]   vld;
    logic [Log2W:0]   ovr;
    logic [WIDTH-1:0] dat [Log2W+1];
    logic [2:0]       opc [Log2W+1];
    logic [TAGW-1:0]  tg  [Log2W+1];
    logic [Log2W-1:0] sh  [Log2W+1];
    logic             unused_sh;

    assign stall      = out_valid_o & ~out_ready_i;
    assign advance    = ~stall;
    assign in_ready_o = ~stall;

    assign vld[0] = in_valid_i;
    assign dat[0] = d_i;
    assign opc[0] = op_i;
    assign tg[0]  = tag_i;
    assign ovr[0] = |s_i[WIDTH-1:Log2W];
    assign sh[0]  = s_i[Log2W-1:0];

    for (genvar k = 0; k < Log2W; k++) begin : g_stage
        shifter_stage #(
            .WIDTH (WIDTH),
            .AMT   (2 ** k),
            .TAGW  (TAGW),
            .SHW   (Log2W)
        ) u_stage (
            .clk_i   (clk_i),
            .rst_n   (rst_n),
            .en_i    (advance),
            .valid_i (vld[k]),
            .data_i  (dat[k]),
            .op_i    (opc[k]),
            .tag_i   (tg[k]),
            .ovr_i   (ovr[k]),
            .sh_i    (sh[k]),
            .valid_o (vld[k+1]),
            .data_o  (dat[k+1]),
            .op_o    (opc[k+1]),
            .tag_o   (tg[k+1]),
            .ovr_o   (ovr[k+1]),
            .sh_o    (sh[k+1])
        );
    end

    assign unused_sh = ^sh[Log2W];

    assign out_valid_o = vld[Log2W];
    assign tag_o       = tg[Log2W];

    // Rotates ignore overrange; logical shifts collapse to zero, SRA to the sign.
    always_comb begin
        op_err_o = (opc[Log2W] > OpRol);
        y_o      = dat[Log2W];
        if (!op_err_o && ovr[Log2W]) begin
            case (opc[Log2W])
                OpSrl, OpSll: y_o = '0;
                OpSra:        y_o = {WIDTH{dat[Log2W][WIDTH-1]}};
                default:      y_o = dat[Log2W];
            endcase
        end
    end

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter: directed spec vectors, backpressure, reset
// mid-flight and randomized traffic against an arithmetic reference model.
module tb_pipelined_shifter;
    import pipelined_shifter_pkg::*;

    localparam int unsigned W   = 32;
    localparam int unsigned TW  = 4;
    localparam int          LAT = 5;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  d;
    logic [W-1:0]  s;
    logic [2:0]    op;
    logic [TW-1:0] tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  y;
    logic [TW-1:0] tag_out;
    logic          op_err;

    pipelined_shifter #(
        .WIDTH (W),
        .TAGW  (TW)
    ) dut (
        .clk_i       (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .d_i         (d),
        .s_i         (s),
        .op_i        (op),
        .tag_i       (tag),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .y_o         (y),
        .tag_o       (tag_out),
        .op_err_o    (op_err)
    );

    typedef struct {
        logic [W-1:0]  y;
        logic [TW-1:0] tag;
        logic          err;
        int            acc;
        bit            lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: shift by the full S value, saturating for shifts, modulo for rotates.
    function automatic logic [W-1:0] model(input logic [W-1:0] dv, input logic [W-1:0] sv,
                                           input logic [2:0] ov);
        logic [63:0] dd;
        logic [63:0] t;
        int unsigned r;
        r  = sv % W;
        dd = {dv, dv};
        case (ov)
            3'd0: model = (sv >= W) ? '0 : dv >> sv;
            3'd1: model = (sv >= W) ? '0 : dv << sv;
            3'd2: model = (sv >= W) ? {W{dv[W-1]}} : W'($signed(dv) >>> sv);
            3'd3: begin t = dd >> r; model = t[W-1:0]; end
            3'd4: begin t = dd << r; model = t[2*W-1:W]; end
            default: model = dv;
        endcase
    endfunction

    // Called at a falling edge; offers one cycle of stimulus and returns at the next one.
    task automatic drive(input bit v, input logic [W-1:0] dv, input logic [W-1:0] sv,
                         input logic [2:0] ov, input logic [TW-1:0] tv, input bit ordy,
                         input bit use_exp, input logic [W-1:0] ey, input bit lat,
                         output bit acc);
        exp_t e;
        in_valid  = v;
        d         = dv;
        s         = sv;
        op        = ov;
        tag       = tv;
        out_ready = ordy;
        #1;
        acc = v && in_ready;
        if (acc) begin
            e.y   = use_exp ? ey : model(dv, sv, ov);
            e.tag = tv;
            e.err = (ov > 3'd4);
            e.acc = cyc + 1;
            e.lat = lat;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    logic          prev_stall = 0;
    logic [W-1:0]  prev_y;
    logic [TW-1:0] prev_tag;
    logic          prev_err;

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst_n) begin
            prev_stall = 0;
        end else if (mon_en) begin
            check("in_ready", in_ready, !(out_valid && !out_ready));
            if (prev_stall && out_valid) begin
                check("hold_y", y, prev_y);
                check("hold_tag", tag_out, prev_tag);
                check("hold_err", op_err, prev_err);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got tag %0h y %0h, required no result",
                             tag_out, y);
                end else begin
                    e = sb.pop_front();
                    check("y", y, e.y);
                    check("tag", tag_out, e.tag);
                    check("op_err", op_err, e.err);
                    if (e.lat) check("latency", cyc + 1 - e.acc, LAT);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_y     = y;
            prev_tag   = tag_out;
            prev_err   = op_err;
        end
    end

    logic [W-1:0] dir_d  [16];
    logic [W-1:0] dir_s  [16];
    logic [2:0]   dir_op [16];
    logic [W-1:0] dir_y  [16];

    initial begin
        bit acc;
        int idx;
        int guard;
        clk       = 0;
        rst_n     = 0;
        in_valid  = 0;
        d         = '0;
        s         = '0;
        op        = '0;
        tag       = '0;
        out_ready = 1;

        dir_d[0]  = 32'h0000_0001; dir_s[0]  = 32'd31;   dir_op[0]  = 3'd1; dir_y[0]  = 32'h8000_0000;
        dir_d[1]  = 32'h0000_0001; dir_s[1]  = 32'd32;   dir_op[1]  = 3'd1; dir_y[1]  = 32'h0000_0000;
        dir_d[2]  = 32'h8000_0000; dir_s[2]  = 32'd4;    dir_op[2]  = 3'd2; dir_y[2]  = 32'hF800_0000;
        dir_d[3]  = 32'h8000_0000; dir_s[3]  = 32'h40;   dir_op[3]  = 3'd2; dir_y[3]  = 32'hFFFF_FFFF;
        dir_d[4]  = 32'h8000_0000; dir_s[4]  = 32'h40;   dir_op[4]  = 3'd0; dir_y[4]  = 32'h0000_0000;
        dir_d[5]  = 32'h0000_0001; dir_s[5]  = 32'd33;   dir_op[5]  = 3'd3; dir_y[5]  = 32'h8000_0000;
        dir_d[6]  = 32'h8000_0001; dir_s[6]  = 32'd1;    dir_op[6]  = 3'd4; dir_y[6]  = 32'h0000_0003;
        dir_d[7]  = 32'h1234_5678; dir_s[7]  = 32'd5;    dir_op[7]  = 3'd7; dir_y[7]  = 32'h1234_5678;
        dir_d[8]  = 32'h1234_5678; dir_s[8]  = 32'h100;  dir_op[8]  = 3'd5; dir_y[8]  = 32'h1234_5678;
        dir_d[9]  = 32'hA5A5_F00F; dir_s[9]  = 32'd0;    dir_op[9]  = 3'd0; dir_y[9]  = 32'hA5A5_F00F;
        dir_d[10] = 32'hA5A5_F00F; dir_s[10] = 32'd0;    dir_op[10] = 3'd1; dir_y[10] = 32'hA5A5_F00F;
        dir_d[11] = 32'hA5A5_F00F; dir_s[11] = 32'd0;    dir_op[11] = 3'd2; dir_y[11] = 32'hA5A5_F00F;
        dir_d[12] = 32'hA5A5_F00F; dir_s[12] = 32'd0;    dir_op[12] = 3'd3; dir_y[12] = 32'hA5A5_F00F;
        dir_d[13] = 32'hA5A5_F00F; dir_s[13] = 32'd0;    dir_op[13] = 3'd4; dir_y[13] = 32'hA5A5_F00F;
        dir_d[14] = 32'h8000_0000; dir_s[14] = 32'd36;   dir_op[14] = 3'd4; dir_y[14] = 32'h0000_0008;
        dir_d[15] = 32'h0000_00F0; dir_s[15] = 32'd4;    dir_op[15] = 3'd0; dir_y[15] = 32'h0000_000F;

        #3;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_y", y, 0);
        check("reset_tag", tag_out, 0);
        check("reset_op_err", op_err, 0);

        @(negedge clk);
        rst_n  = 1;
        mon_en = 1;

        // Directed vectors, back-to-back with no backpressure.
        for (int i = 0; i < 16; i++) begin
            drive(1, dir_d[i], dir_s[i], dir_op[i], TW'(i), 1, 1, dir_y[i], 1, acc);
            check("directed_accept", acc, 1);
        end
        for (int i = 0; i < 8; i++) drive(0, '0, '0, '0, '0, 1, 0, '0, 0, acc);

        // Eight back-to-back ops with a four-cycle consumer stall.
        idx   = 0;
        guard = 0;
        for (int i = 0; i < 40 && (idx < 8 || sb.size() != 0); i++) begin
            drive(idx < 8, $urandom, $urandom_range(0, 40), 3'($urandom_range(0, 7)), TW'(idx),
                  !(i >= 5 && i <= 8), 0, '0, 0, acc);
            if (acc) idx++;
            guard = i;
        end
        check("backpressure_all_sent", idx, 8);
        check("backpressure_drained", sb.size(), 0);

        // Reset with operations in flight.
        for (int i = 0; i < 6; i++) drive(1, $urandom, $urandom_range(0, 31), 3'd1, TW'(i), 1, 0,
                                          '0, 0, acc);
        in_valid = 0;
        check("preflight_valid", out_valid, 1);
        #3;
        rst_n = 0;
        #1;
        sb.delete();
        check("midreset_out_valid", out_valid, 0);
        check("midreset_in_ready", in_ready, 1);
        check("midreset_y", y, 0);
        check("midreset_tag", tag_out, 0);
        check("midreset_op_err", op_err, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 10; i++) drive(0, '0, '0, '0, '0, 1, 0, '0, 0, acc);
        drive(1, 32'h0000_0001, 32'd3, 3'd1, 4'hA, 1, 1, 32'h0000_0008, 1, acc);
        check("post_reset_accept", acc, 1);

        // Randomized traffic with random consumer backpressure.
        idx   = 0;
        guard = 0;
        while (idx < 300 && guard < 5000) begin
            logic [W-1:0] sv;
            sv = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 40));
            drive($urandom_range(0, 3) != 0, $urandom, sv, 3'($urandom_range(0, 7)),
                  TW'($urandom), $urandom_range(0, 9) < 7, 0, '0, 0, acc);
            if (acc) idx++;
            guard++;
        end
        check("random_all_sent", idx, 300);

        for (int i = 0; i < 100 && sb.size() != 0; i++) drive(0, '0, '0, '0, '0, 1, 0, '0, 0, acc);
        drive(0, '0, '0, '0, '0, 1, 0, '0, 0, acc);
        check("final_drain", sb.size(), 0);
        check("final_idle", out_valid, 0);

        mon_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_shifter.md
PIPELINED_SHIFTER -- requirements
Module: pipelined_shifter

Interface
REQ-001 Parameter WIDTH, default 32, data width; SHALL be a power of two, 8..64.
REQ-002 Parameter TAGW, default 4, width of the sideband tag carried with each operation.
REQ-003 Derived constant LOG2W = log2(WIDTH) SHALL set the stage count and the latency.
REQ-004 CLK  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 RST  input  1  asynchronous, active-low reset.
REQ-006 IN_VALID  input  1  operation offered.
REQ-007 IN_READY  output  1  operation accepted when IN_VALID & IN_READY at CLK rise.
REQ-008 D  input  WIDTH  operand.
REQ-009 S  input  WIDTH  shift amount; the full word is significant.
REQ-010 OP  input  3  000 SRL, 001 SLL, 010 SRA, 011 ROR, 100 ROL, 101..111 reserved.
REQ-011 TAG_IN  input  TAGW  sideband, returned unchanged with the result.
REQ-012 OUT_VALID  output  1  result available.
REQ-013 OUT_READY  input  1  consumer accepts the result when OUT_VALID & OUT_READY.
REQ-014 Y  output  WIDTH  result.
REQ-015 TAG_OUT  output  TAGW  tag of the current result.
REQ-016 OP_ERR  output  1  the current result came from a reserved OP.

Function
REQ-017 Stage k (k = 0..LOG2W-1) SHALL conditionally shift or rotate by 2^k, selected by S[k], and register its result, valid bit, OP, tag and the control bits it needs.
REQ-018 Latency SHALL be exactly LOG2W cycles from acceptance to OUT_VALID when there is no backpressure.
REQ-019 Throughput SHALL be one operation per cycle.
REQ-020 Stall rule: stall = OUT_VALID & ~OUT_READY; IN_READY = ~stall.
REQ-021 While stall is high, every stage register SHALL hold its value.
REQ-022 While stall is low, the pipeline SHALL advance and bubbles SHALL propagate as valid=0.
REQ-023 Overrange: OVR = OR(S[WIDTH-1:LOG2W]), computed at acceptance and carried with the operation.
REQ-024 SRL and SLL with OVR=1 SHALL return 0.
REQ-025 SRA with OVR=1 SHALL return all bits equal to D[WIDTH-1].
REQ-026 SRA SHALL fill vacated bits with D[WIDTH-1].
REQ-027 SRL and SLL SHALL fill vacated bits with 0.
REQ-028 ROR and ROL SHALL ignore OVR: rotate amount = S mod WIDTH.
REQ-029 Reserved OP SHALL return Y = D unshifted with OP_ERR=1; for any valid OP, OP_ERR=0.
REQ-030 S[LOG2W-1:0]=0 with OVR=0 SHALL return D for every OP.
REQ-031 Y, TAG_OUT and OP_ERR SHALL be stable while OUT_VALID=1 and OUT_READY=0.
REQ-032 Results SHALL leave in acceptance order; no operation SHALL be dropped or duplicated.

Reset
REQ-033 RST low SHALL immediately clear all stage valid bits, so OUT_VALID=0 and IN_READY=1.
REQ-034 RST low SHALL immediately clear Y, TAG_OUT and OP_ERR to 0.
REQ-035 Operations in flight when RST asserts SHALL be discarded.
REQ-036 The first acceptance SHALL be possible on the first CLK rise after RST deasserts.

Structure
REQ-037 A shared package SHALL hold the OP encodings, the clog2 function and the default WIDTH and TAGW.
REQ-038 One sub-module, shifter_stage (parameters WIDTH and AMT = 2^k), SHALL implement the mux plus register for one stage.
REQ-039 The top level SHALL generate LOG2W instances of shifter_stage.
REQ-040 The top level SHALL also contain the OVR reduction, the stall logic and the final overrange/sign-fill select.

Verification (WIDTH=32, so latency is 5)
REQ-041 SLL D=0x00000001, S=31 -> Y=0x80000000 on cycle 5; S=32 -> Y=0x00000000.
REQ-042 SRA D=0x80000000, S=4 -> Y=0xF8000000; S=0x40 -> Y=0xFFFFFFFF; SRL D=0x80000000, S=0x40 -> Y=0.
REQ-043 ROR D=0x00000001, S=33 -> Y=0x80000000; ROL D=0x80000001, S=1 -> Y=0x00000003.
REQ-044 Backpressure: 8 back-to-back ops (tags 0..7) with OUT_READY low on cycles 6..9 -> all 8 results in tag order; Y held while stalled; IN_READY low exactly during the stall.
REQ-045 Reset mid-flight: 3 ops in the pipe, RST pulsed low -> OUT_VALID=0 at once; no stale result appears after release.
REQ-046 OP=111, D=0x12345678 -> Y=0x12345678, OP_ERR=1.
